// File: rtl/seg_scan_driver_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_driver_pkg
// Shared definitions for the seven-segment scan driver:
//   SEG_OFF       - all-dark segment pattern in the decoder's active-high domain
//   scan_state_e  - scan FSM states (blank interval / digit shown)
//   clog2         - ceiling log2 used to size the dwell timer and digit index
// -----------------------------------------------------------------------------
package seg_scan_driver_pkg;

    // Decoder output with every segment dark (bit 0 = a ... bit 6 = g, 1 = lit).
    localparam logic [6:0] SEG_OFF = 7'h00;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // Smallest n with 2**n >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bcdto7seg.sv
// -----------------------------------------------------------------------------
// bcdto7seg
// Combinational nibble to seven-segment decoder, active-high outputs.
// Digits 0-9 use the standard glyphs, A-F the usual hex glyphs (A b C d E F).
// Ports:
//   bcd  in  4  nibble to decode
//   seg  out 7  segments, bit 0 = a ... bit 6 = g, 1 = lit
// -----------------------------------------------------------------------------
module bcdto7seg (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Glyph lookup.
    always_comb begin
        seg = 7'h00;
        case (bcd)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed scanner for a multi-digit seven-segment display. A loaded
// digit word is held in a pending register and copied into the display
// register only when digit 0 of a new frame starts, so one frame never mixes
// old and new digits. Each digit is shown for DWELL cycles, separated by BLANK
// cycles with every select off.
// Ports:
//   CLOCK_50    in   1         system clock
//   reset       in   1         synchronous, active-low
//   digits_in   in   4*DIGITS  nibble i at [4i+3:4i], digit 0 least significant
//   load        in   1         capture digits_in/dp_in into the pending register
//   dp_in       in   DIGITS    decimal point per digit, 1 = lit
//   seg_out     out  7         segments a..g of the selected digit
//   dp_out      out  1         decimal point of the selected digit
//   sel         out  DIGITS    one-hot digit enable, all zero while blanking
//   frame_done  out  1         pulse as the last digit's dwell ends
// -----------------------------------------------------------------------------
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int DWELL          = 65536,
    parameter int BLANK          = 256,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit LZB            = 1'b1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic                  load,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     sel,
    output logic                  frame_done
);

    localparam int SPAN   = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int TW     = (clog2(SPAN) < 1) ? 1 : clog2(SPAN);
    localparam int IW     = clog2(DIGITS);

    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    // Pin polarity: XOR turns the decoder's active-high pattern into pin levels.
    localparam logic [6:0] POL_MASK    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0] SEG_OFF_PIN = SEG_OFF ^ POL_MASK;

    scan_state_e            state_r;
    scan_state_e            state_next_s;
    logic [TW-1:0]          timer_r;
    logic [TW-1:0]          timer_next_s;
    logic [IW-1:0]          idx_r;
    logic [IW-1:0]          idx_next_s;

    logic [4*DIGITS-1:0]    pend_digits_r;
    logic [DIGITS-1:0]      pend_dp_r;
    logic                   pend_valid_r;
    logic [4*DIGITS-1:0]    disp_digits_r;
    logic [DIGITS-1:0]      disp_dp_r;
    logic [4*DIGITS-1:0]    disp_digits_next_s;
    logic [DIGITS-1:0]      disp_dp_next_s;

    logic                   transfer_s;
    logic                   show_next_s;
    logic                   frame_done_next_s;

    logic [3:0]             nibble_s;
    logic                   dp_sel_s;
    logic                   upper_nonzero_s;
    logic                   blanked_s;
    logic [DIGITS-1:0]      sel_onehot_s;
    logic [6:0]             dec_seg_s;
    logic [6:0]             seg_lit_s;

    // Scan FSM: blank/show sequencing, dwell timer and digit index advance.
    always_comb begin
        state_next_s      = state_r;
        timer_next_s      = timer_r;
        idx_next_s        = idx_r;
        transfer_s        = 1'b0;
        show_next_s       = 1'b0;
        frame_done_next_s = 1'b0;
        case (state_r)
            ST_BLANK: begin
                if (timer_r == BLANK_LAST) begin
                    state_next_s = ST_SHOW;
                    timer_next_s = {TW{1'b0}};
                    show_next_s  = 1'b1;
                    // Frame boundary: new digits only enter as digit 0 starts.
                    transfer_s   = (idx_r == {IW{1'b0}}) && pend_valid_r;
                end else begin
                    timer_next_s = timer_r + TW'(1);
                end
            end
            ST_SHOW: begin
                if (timer_r == DWELL_LAST) begin
                    state_next_s = ST_BLANK;
                    timer_next_s = {TW{1'b0}};
                    if (idx_r == IDX_LAST) begin
                        idx_next_s        = {IW{1'b0}};
                        frame_done_next_s = 1'b1;
                    end else begin
                        idx_next_s = idx_r + IW'(1);
                    end
                end else begin
                    timer_next_s = timer_r + TW'(1);
                    show_next_s  = 1'b1;
                end
            end
            default: begin
                state_next_s = ST_BLANK;
                timer_next_s = {TW{1'b0}};
                idx_next_s   = {IW{1'b0}};
            end
        endcase
    end

    // Display contents for the coming cycle, including a same-edge transfer so
    // digit 0 shows the new value from its very first cycle.
    always_comb begin
        disp_digits_next_s = disp_digits_r;
        disp_dp_next_s     = disp_dp_r;
        if (transfer_s) begin
            disp_digits_next_s = pend_digits_r;
            disp_dp_next_s     = pend_dp_r;
        end else begin
            disp_digits_next_s = disp_digits_r;
            disp_dp_next_s     = disp_dp_r;
        end
    end

    // Digit mux ahead of the single decoder, select pattern and leading-zero test.
    always_comb begin
        nibble_s        = 4'h0;
        dp_sel_s        = 1'b0;
        upper_nonzero_s = 1'b0;
        sel_onehot_s    = {DIGITS{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            sel_onehot_s[i] = (IW'(i) == idx_r);
            nibble_s        = nibble_s | (sel_onehot_s[i] ? disp_digits_next_s[4*i +: 4] : 4'h0);
            dp_sel_s        = dp_sel_s | (sel_onehot_s[i] & disp_dp_next_s[i]);
            upper_nonzero_s = upper_nonzero_s |
                              ((IW'(i) >= idx_r) && (disp_digits_next_s[4*i +: 4] != 4'h0));
        end
        // Digit 0 always shows; higher digits go dark while they and everything above are zero.
        blanked_s = LZB && (idx_r != {IW{1'b0}}) && !upper_nonzero_s;
        seg_lit_s = blanked_s ? SEG_OFF : dec_seg_s;
    end

    bcdto7seg u_dec (
        .bcd (nibble_s),
        .seg (dec_seg_s)
    );

    // State, load/transfer registers and registered display outputs.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_r       <= ST_BLANK;
            timer_r       <= {TW{1'b0}};
            idx_r         <= {IW{1'b0}};
            pend_digits_r <= {(4*DIGITS){1'b0}};
            pend_dp_r     <= {DIGITS{1'b0}};
            pend_valid_r  <= 1'b0;
            disp_digits_r <= {(4*DIGITS){1'b0}};
            disp_dp_r     <= {DIGITS{1'b0}};
            sel           <= {DIGITS{1'b0}};
            seg_out       <= SEG_OFF_PIN;
            dp_out        <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            timer_r       <= timer_next_s;
            idx_r         <= idx_next_s;
            disp_digits_r <= disp_digits_next_s;
            disp_dp_r     <= disp_dp_next_s;
            // A load on the transfer edge stays pending for the next frame.
            if (load) begin
                pend_digits_r <= digits_in;
                pend_dp_r     <= dp_in;
                pend_valid_r  <= 1'b1;
            end else if (transfer_s) begin
                pend_valid_r  <= 1'b0;
            end else begin
                pend_valid_r  <= pend_valid_r;
            end
            if (show_next_s) begin
                sel     <= sel_onehot_s;
                seg_out <= seg_lit_s ^ POL_MASK;
                dp_out  <= dp_sel_s;
            end else begin
                sel     <= {DIGITS{1'b0}};
                seg_out <= SEG_OFF_PIN;
                dp_out  <= 1'b0;
            end
            frame_done <= frame_done_next_s;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
// Scoreboard bench: a frame-level reference model derives, from the cycle
// position inside the frame, what the display should show after every clock
// edge and queues it; a monitor compares the DUT outputs on the falling edge.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int DIGITS = 4;
    localparam int DWELL  = 4;
    localparam int BLANK  = 2;
    localparam int SLOT   = DWELL + BLANK;
    localparam int FRAME  = DIGITS * SLOT;

    logic                CLOCK_50 = 1'b0;
    logic                reset    = 1'b0;
    logic [4*DIGITS-1:0] digits_in = 16'h0000;
    logic                load     = 1'b0;
    logic [DIGITS-1:0]   dp_in    = 4'h0;
    logic [6:0]          seg_out;
    logic                dp_out;
    logic [DIGITS-1:0]   sel;
    logic                frame_done;

    typedef struct packed {
        logic [3:0] sel;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    seg_scan_driver #(
        .DIGITS         (DIGITS),
        .DWELL          (DWELL),
        .BLANK          (BLANK),
        .SEG_ACTIVE_LOW (1'b1),
        .LZB            (1'b1)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .digits_in  (digits_in),
        .load       (load),
        .dp_in      (dp_in),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .sel        (sel),
        .frame_done (frame_done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Standard glyphs, bit 0 = a ... bit 6 = g, 1 = lit.
    function automatic logic [6:0] glyph(input int n);
        case (n)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
            12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; 15: return 7'h71;
            default: return 7'h00;
        endcase
    endfunction

    // Reference model: frame position arithmetic plus pending/display words.
    initial begin
        logic [15:0] pend_d, disp_d;
        logic [3:0]  pend_p, disp_p;
        bit          pend_v;
        int          p, slot, w, nib;
        obs_t        e;
        pend_d = 16'h0; disp_d = 16'h0; pend_p = 4'h0; disp_p = 4'h0; pend_v = 1'b0;
        forever begin
            @(posedge CLOCK_50);
            if (!reset) begin
                cyc = 0; pend_d = 16'h0; disp_d = 16'h0;
                pend_p = 4'h0; disp_p = 4'h0; pend_v = 1'b0;
                e = '{sel: 4'h0, seg: 7'h7F, dp: 1'b0, fd: 1'b0};
            end else begin
                cyc  = cyc + 1;
                p    = cyc % FRAME;
                slot = p / SLOT;
                w    = p % SLOT;
                if (p == BLANK && pend_v) begin
                    disp_d = pend_d; disp_p = pend_p; pend_v = 1'b0;
                end
                if (load) begin
                    pend_d = digits_in; pend_p = dp_in; pend_v = 1'b1;
                end
                if (w < BLANK) begin
                    e = '{sel: 4'h0, seg: 7'h7F, dp: 1'b0, fd: (p == 0)};
                end else begin
                    nib   = int'(disp_d[4*slot +: 4]);
                    e.sel = 4'(1 << slot);
                    e.seg = (slot > 0 && (disp_d >> (4*slot)) == 16'h0) ? 7'h7F : ~glyph(nib);
                    e.dp  = disp_p[slot];
                    e.fd  = 1'b0;
                end
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: every clock the DUT presents a display state; compare on the falling edge.
    initial begin
        obs_t e, got;
        forever begin
            @(negedge CLOCK_50);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = '{sel: sel, seg: seg_out, dp: dp_out, fd: frame_done};
                checks = checks + 1;
                if (got !== e) begin
                    errors = errors + 1;
                    $display("FAIL scan cyc=%0d got sel=%b seg=%h dp=%b fd=%b want sel=%b seg=%h dp=%b fd=%b",
                             cyc, got.sel, got.seg, got.dp, got.fd, e.sel, e.seg, e.dp, e.fd);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
        digits_in = d;
        dp_in     = dp;
        load      = 1'b1;
        @(negedge CLOCK_50);
        load      = 1'b0;
    endtask

    // Wait (bounded) until the cycle now on the outputs sits at a given frame position.
    task automatic wait_phase(input int target);
        int n;
        n = 0;
        while ((cyc % FRAME) != target && n < 2*FRAME) begin
            @(negedge CLOCK_50);
            n = n + 1;
        end
        if ((cyc % FRAME) != target) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL wait_phase got=%0d want=%0d", cyc % FRAME, target);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [15:0] d;
        tick(3);
        reset = 1'b1;
        tick(2*FRAME);                                // power-up: "0" with LZB

        tick(7); do_load(16'h1234, 4'b0100);          // mid-frame load
        tick(2*FRAME);

        wait_phase(3); do_load(16'h1111, 4'b0000);    // two loads, last wins
        tick(3);       do_load(16'h2222, 4'b0001);
        tick(2*FRAME);

        wait_phase(10); do_load(16'h5678, 4'b1000);   // load on the transfer edge
        wait_phase(BLANK-1); do_load(16'h9ABC, 4'b0010);
        tick(2*FRAME);

        wait_phase(12); do_load(16'h0050, 4'b0000);   // leading-zero blanking
        tick(2*FRAME);

        for (int i = 0; i < 8; i++) begin
            r = $urandom;
            d = r[15:0] >> (4*$urandom_range(0, 3));
            tick($urandom_range(1, 30));
            r = $urandom;
            do_load(d, r[3:0]);
        end
        tick(2*FRAME);

        wait_phase(8); do_load(16'h8888, 4'b1111);    // pending load then reset in digit 2 SHOW
        wait_phase(15);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(2*FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
